// File: rtl/alu_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_sequencer: fetch/decode/execute controller for the 4-bit CPU;      |
// | owns PC, IR and flags, and sequences memory, A/B loads and the ALU.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module alu_sequencer #(
    parameter int ADDR_W = 4,
    parameter int OPC_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPC_W+ADDR_W-1:0] memData,
    input  logic                    memAck,
    input  logic [2:0]              flagIn,
    output logic [ADDR_W-1:0]       addr,
    output logic                    memRd,
    output logic                    memWr,
    output logic                    Ealu,
    output logic [2:0]              aluOp,
    output logic                    loadA,
    output logic                    loadB,
    output logic                    aSel,
    output logic [ADDR_W-1:0]       pcOut,
    output logic [2:0]              flags,
    output logic                    halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_EXEC1  = 3'd4,
        S_EXEC2  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [OPC_W-1:0] c_OP_LDA = OPC_W'(1);
    localparam logic [OPC_W-1:0] c_OP_LDB = OPC_W'(2);
    localparam logic [OPC_W-1:0] c_OP_ALU = OPC_W'(3);
    localparam logic [OPC_W-1:0] c_OP_STA = OPC_W'(4);
    localparam logic [OPC_W-1:0] c_OP_JMP = OPC_W'(5);
    localparam logic [OPC_W-1:0] c_OP_JZ  = OPC_W'(6);
    localparam logic [OPC_W-1:0] c_OP_JC  = OPC_W'(7);
    localparam logic [OPC_W-1:0] c_OP_HLT = {OPC_W{1'b1}};

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ADDR_W-1:0]         r_pc;
    logic [ADDR_W-1:0]         w_pc_nxt;
    logic [OPC_W+ADDR_W-1:0]   r_ir;
    logic [OPC_W+ADDR_W-1:0]   w_ir_nxt;
    logic [2:0]                r_flags;
    logic [2:0]                w_flags_nxt;
    logic [OPC_W-1:0]          w_opc;
    logic [ADDR_W-1:0]         w_operand;

    assign w_opc     = r_ir[OPC_W+ADDR_W-1:ADDR_W];
    assign w_operand = r_ir[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_flags <= w_flags_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_flags_nxt = r_flags;
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (memAck) begin
                    w_ir_nxt    = memData;
                    w_pc_nxt    = r_pc + ADDR_W'(1);
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // Unlisted opcodes fall through to the default and act as NOP.
                w_state_nxt = S_FETCH;
                case (w_opc)
                    c_OP_LDA, c_OP_LDB, c_OP_STA: w_state_nxt = S_MEM;
                    c_OP_ALU:                     w_state_nxt = S_EXEC1;
                    c_OP_JMP:                     w_pc_nxt = w_operand;
                    c_OP_JZ: if (r_flags[1])      w_pc_nxt = w_operand;
                    c_OP_JC: if (r_flags[0])      w_pc_nxt = w_operand;
                    c_OP_HLT:                     w_state_nxt = S_HALT;
                    default:                      w_state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (memAck) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_EXEC1: w_state_nxt = S_EXEC2;
            S_EXEC2: begin
                w_flags_nxt = flagIn;
                w_state_nxt = S_FETCH;
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode from registered state only, except the memAck-qualified loads.
    always_comb begin
        addr   = '0;
        memRd  = 1'b0;
        memWr  = 1'b0;
        Ealu   = 1'b0;
        aluOp  = 3'b000;
        loadA  = 1'b0;
        loadB  = 1'b0;
        aSel   = 1'b0;
        halted = 1'b0;
        case (r_state)
            S_FETCH: begin
                addr  = r_pc;
                memRd = 1'b1;
            end
            S_MEM: begin
                addr = w_operand;
                case (w_opc)
                    c_OP_LDA: begin
                        memRd = 1'b1;
                        loadA = memAck;
                    end
                    c_OP_LDB: begin
                        memRd = 1'b1;
                        loadB = memAck;
                    end
                    c_OP_STA: memWr = 1'b1;
                    default:  memRd = 1'b0;
                endcase
            end
            S_EXEC1: begin
                Ealu  = 1'b1;
                aluOp = r_ir[2:0];
            end
            S_EXEC2: begin
                Ealu  = 1'b1;
                aluOp = r_ir[2:0];
                loadA = 1'b1;
                aSel  = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    assign pcOut = r_pc;
    assign flags = r_flags;

endmodule
`default_nettype wire
